// File: rtl/mpsub_reduce.sv
// Two-stage borrow-select multi-precision subtractor with optional Montgomery
// final conditional subtraction (mode=1 returns in_a when in_a < in_b).
module mpsub_reduce #(
    parameter int WIDTH = 1028,
    parameter int LIMB  = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             borrow
);

    // The top limb absorbs the leftover bits (128 + 4 = 132 at the defaults).
    localparam int NL   = WIDTH / LIMB;
    localparam int TOPW = WIDTH - (NL - 1) * LIMB;

    logic [WIDTH-1:0]    da_s;
    logic [WIDTH-1:0]    da_q;
    logic [WIDTH-1:LIMB] db_s;
    logic [WIDTH-1:LIMB] db_q;
    logic [NL-1:0]       boa_s;
    logic [NL-1:0]       boa_q;
    logic [NL-1:1]       bob_s;
    logic [NL-1:1]       bob_q;
    logic [WIDTH-1:0]    a_q;
    logic                mode_q;

    logic [NL:1]         br_s;
    logic [WIDTH-1:0]    diff_s;

    logic                s1_valid_q;
    logic                s1_valid_d;
    logic                out_valid_q;
    logic                out_valid_d;
    logic [WIDTH-1:0]    result_q;
    logic [WIDTH-1:0]    result_d;
    logic                borrow_q;
    logic                borrow_d;
    logic                adv2_s;
    logic                accept_s;

    assign br_s[1]                = boa_q[0];
    assign diff_s[LIMB-1:0]       = da_q[LIMB-1:0];

    for (genvar i = 0; i < NL; i++) begin : g_limb
        localparam int LO = i * LIMB;
        localparam int LW = (i == NL - 1) ? TOPW : LIMB;

        logic [LW:0] sa_s;
        assign sa_s               = {1'b0, in_a[LO +: LW]} - {1'b0, in_b[LO +: LW]};
        assign da_s[LO +: LW]     = sa_s[LW-1:0];
        assign boa_s[i]           = sa_s[LW];

        if (i > 0) begin : g_sel
            // a + ~b over LW+1 bits equals a - b - 1; the top bit is its borrow.
            logic [LW:0] sb_s;
            assign sb_s           = {1'b0, in_a[LO +: LW]} + {1'b1, ~in_b[LO +: LW]};
            assign db_s[LO +: LW] = sb_s[LW-1:0];
            assign bob_s[i]       = sb_s[LW];

            assign br_s[i+1]      = br_s[i] ? bob_q[i] : boa_q[i];
            assign diff_s[LO +: LW] = br_s[i] ? db_q[LO +: LW] : da_q[LO +: LW];
        end
    end

    assign adv2_s    = s1_valid_q & (~out_valid_q | out_ready);
    assign in_ready  = ~s1_valid_q | adv2_s;
    assign accept_s  = in_valid & in_ready;

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign borrow    = borrow_q;

    // Next-state for the valid flags and the registered output stage.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        borrow_d    = borrow_q;
        if (accept_s) begin
            s1_valid_d = 1'b1;
        end else if (adv2_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (adv2_s) begin
            out_valid_d = 1'b1;
            borrow_d    = br_s[NL];
            result_d    = (mode_q & br_s[NL]) ? a_q : diff_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Control and output registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            borrow_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            borrow_q    <= borrow_d;
        end
    end

    // Stage-1 limb differences and operand capture; loaded only on accept.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            da_q   <= da_s;
            db_q   <= db_s;
            boa_q  <= boa_s;
            bob_q  <= bob_s;
            a_q    <= in_a;
            mode_q <= mode;
        end
    end

endmodule

// File: tb/tb_mpsub_reduce.sv
// Self-checking bench for mpsub_reduce: directed vector table, reset-in-flight
// sequence and a randomized stream against a plain-arithmetic reference model.
module tb_mpsub_reduce;

    localparam int W = 1028;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         borrow;

    mpsub_reduce #(.WIDTH(W), .LIMB(128)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .borrow    (borrow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         m;
        logic [W-1:0] res;
        logic         bor;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         bor;
    } exp_t;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t expq[$];
    vec_t tbl[13];

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        for (int k = 0; k < W; k += 32) begin
            v = (v << 32) | W'($urandom);
        end
        return v;
    endfunction

    // Reference: whole-width unsigned arithmetic, no limbs.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        exp_t e;
        e.bor = (a < b);
        e.res = (m && e.bor) ? a : (a - b);
        return e;
    endfunction

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_res(input string nm, input logic [W-1:0] ar, input logic ab,
                           input logic [W-1:0] er, input logic eb);
        n_cmp++;
        if (ar !== er || ab !== eb) begin
            n_err++;
            $display("FAIL %s: got res_lo128=%h hi=%h bor=%b expected res_lo128=%h hi=%h bor=%b",
                     nm, ar[127:0], ar[W-1:W-4], ab, er[127:0], er[W-1:W-4], eb);
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        @(negedge clk);
        in_valid = 1'b1; in_a = v.a; in_b = v.b; mode = v.m; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_a = rand_wide(); in_b = rand_wide(); mode = ~v.m;
        chk_bit($sformatf("vec%0d_early_valid", idx), out_valid, 1'b0);
        @(negedge clk);
        chk_bit($sformatf("vec%0d_valid", idx), out_valid, 1'b1);
        chk_res($sformatf("vec%0d_result", idx), result, borrow, v.res, v.bor);
    endtask

    logic         stall_prev = 1'b0;
    logic [W-1:0] prev_res;
    logic         prev_bor;

    task automatic stream_cycle(input logic drive);
        exp_t e;
        @(negedge clk);
        if (stall_prev) begin
            chk_bit("stall_valid_hold", out_valid, 1'b1);
            chk_res("stall_data_hold", result, borrow, prev_res, prev_bor);
        end
        in_valid  = drive ? 1'($urandom_range(0, 3) != 0) : 1'b0;
        in_a      = rand_wide();
        in_b      = ($urandom_range(0, 7) == 0) ? in_a : rand_wide();
        mode      = 1'($urandom);
        out_ready = 1'($urandom);
        #1;
        chk_bit("in_ready", in_ready, !(expq.size() == 2 && !out_ready));
        if (out_valid) begin
            if (expq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL spurious_out: out_valid=1 with no beat outstanding");
            end else if (out_ready) begin
                e = expq.pop_front();
                chk_res("stream_result", result, borrow, e.res, e.bor);
            end
        end
        stall_prev = out_valid && !out_ready;
        prev_res   = result;
        prev_bor   = borrow;
        if (in_valid && in_ready) expq.push_back(model(in_a, in_b, mode));
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] m_odd;
        logic [W-1:0] p128;
        logic [W-1:0] ptop;
        logic [W-1:0] p200;
        vec_t         v;
        int           guard;

        ones  = {W{1'b1}};
        m_odd = rand_wide();
        m_odd[W-1] = 1'b0;
        m_odd[W-2] = 1'b1;
        m_odd[0]   = 1'b1;
        p128  = {W{1'b0}}; p128[128]  = 1'b1;
        ptop  = {W{1'b0}}; ptop[W-1]  = 1'b1;
        p200  = {W{1'b0}}; p200[200]  = 1'b1;

        tbl[0]  = '{W'(5),       W'(3),       1'b0, W'(2),            1'b0};
        tbl[1]  = '{W'(3),       W'(5),       1'b0, ones - W'(1),     1'b1};
        tbl[2]  = '{p128,        W'(1),       1'b0, p128 - W'(1),     1'b0};
        tbl[3]  = '{W'(0),       W'(1),       1'b1, W'(0),            1'b1};
        tbl[4]  = '{m_odd + W'(7), m_odd,     1'b1, W'(7),            1'b0};
        tbl[5]  = '{W'(0),       W'(1),       1'b0, ones,             1'b1};
        tbl[6]  = '{ones,        ones,        1'b0, W'(0),            1'b0};
        tbl[7]  = '{ones,        ones,        1'b1, W'(0),            1'b0};
        tbl[8]  = '{W'(0),       W'(0),       1'b0, W'(0),            1'b0};
        tbl[9]  = '{W'(0),       W'(0),       1'b1, W'(0),            1'b0};
        tbl[10] = '{ptop,        W'(1),       1'b0, ptop - W'(1),     1'b0};
        tbl[11] = '{W'(0),       ones,        1'b0, W'(1),            1'b1};
        tbl[12] = '{W'(7),       p200,        1'b1, W'(7),            1'b1};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; mode = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_bit("reset_out_valid", out_valid, 1'b0);
        chk_bit("reset_in_ready", in_ready, 1'b1);
        chk_res("reset_result", result, borrow, W'(0), 1'b0);

        for (int i = 0; i < 13; i++) apply_vec(tbl[i], i);

        // Two beats in flight under stall, then reset discards both.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_a = W'(100); in_b = W'(1); mode = 1'b0;
        @(negedge clk);
        in_a = W'(200); in_b = W'(2);
        @(negedge clk);
        in_valid = 1'b0;
        chk_bit("t5_full_in_ready", in_ready, 1'b0);
        chk_bit("t5_full_out_valid", out_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        chk_bit("t5_reset_out_valid", out_valid, 1'b0);
        chk_bit("t5_reset_in_ready", in_ready, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk_bit("t5_no_old_beat", out_valid, 1'b0);
        end
        v = '{W'(9), W'(4), 1'b1, W'(5), 1'b0};
        apply_vec(v, 99);

        for (int i = 0; i < 1000; i++) stream_cycle(1'b1);
        guard = 0;
        while (expq.size() != 0 && guard < 50) begin
            stream_cycle(1'b0);
            guard++;
        end
        n_cmp++;
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d beats never emerged, expected 0", expq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
